// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with oversampled bit recovery and show-ahead RX FIFO
//
// Purpose: recovers LSB-first 8N1 frames from rx_bit_i using a per-frame
// latched baud divisor, pushes good bytes into a show-ahead FIFO and pulses
// frame_err_o / overrun_o on bad stop bits or a full FIFO.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   baud_div_i   clk_i cycles per bit (>= 4), latched at frame start
//   rx_en_i      receiver enable; 0 aborts any frame in progress
//   rx_bit_i     asynchronous serial input, idle high
//   rx_re_i      pop FIFO head (ignored while empty)
//   dout_o       FIFO head, valid while empty_o=0
//   empty_o      FIFO empty
//   full_o       FIFO holds FIFO_DEPTH entries
//   frame_err_o  1-cycle pulse: stop bit sampled 0, byte discarded
//   overrun_o    1-cycle pulse: good byte dropped because FIFO full
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           baud_div_i,
  input  logic                  rx_en_i,
  input  logic                  rx_bit_i,
  input  logic                  rx_re_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [15:0]           baud_cnt_q, baud_cnt_d;
  logic [15:0]           div_q, div_d;
  logic [BW-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           count_q;

  logic tick, half_tick, push, pop, good_stop;

  // Full bit period elapsed / middle of the start bit reached.
  assign tick      = (baud_cnt_q == (div_q - 16'd1));
  assign half_tick = (baud_cnt_q == ((div_q >> 1) - 16'd1));

  // Two-flop synchronizer, preset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_bit_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State register together with the frame datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s_q) state_d = S_START;
      S_START: if (half_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (tick && (bit_idx_q == LAST_BIT)) state_d = S_STOP;
      S_STOP:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!rx_en_i) state_d = S_IDLE;
  end

  // Baud counter, divisor latch, bit index and shift register.
  always_comb begin
    baud_cnt_d = baud_cnt_q + 16'd1;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        if (rx_en_i && !rx_s_q) div_d = baud_div_i;
      end
      S_START: begin
        if (half_tick) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          baud_cnt_d         = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + BW'(1);
        end
      end
      S_STOP: begin
        if (tick) baud_cnt_d = '0;
      end
      default: baud_cnt_d = '0;
    endcase
  end

  // Output logic: stop-bit verdict and FIFO handshake.
  always_comb begin
    pop         = rx_re_i && !empty_o;
    good_stop   = rx_en_i && (state_q == S_STOP) && tick && rx_s_q;
    frame_err_o = rx_en_i && (state_q == S_STOP) && tick && !rx_s_q;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    push        = good_stop && (!full_o || pop);
    overrun_o   = good_stop && full_o && !pop;
  end

  // Show-ahead FIFO; storage is cleared on reset so dout_o reads 0 afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW + 1)'(1);
        2'b01:   count_q <= count_q - (PW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx_en;
  logic        rx_bit;
  logic        rx_re;
  logic [7:0]  dout;
  logic        empty;
  logic        full;
  logic        frame_err;
  logic        overrun;

  int          total = 0;
  int          bad = 0;
  int          ferr_cnt = 0;
  int          ovr_cnt = 0;
  int          div = 104;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .baud_div_i (baud_div),
    .rx_en_i    (rx_en),
    .rx_bit_i   (rx_bit),
    .rx_re_i    (rx_re),
    .dout_o     (dout),
    .empty_o    (empty),
    .full_o     (full),
    .frame_err_o(frame_err),
    .overrun_o  (overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts error pulses and checks every popped byte against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_re && !empty) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got 0x%0h expected no data", dout);
        end else begin
          check("pop_data", int'(dout), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int cycles);
    rx_bit = b;
    tick(cycles);
  endtask

  // Bad stop bits are held low for 3/4 of a bit so the line is clearly idle
  // again before the receiver's false-start check.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    send_bit(1'b0, div);
    for (int i = 0; i < 8; i++) send_bit(d[i], div);
    if (stop_ok) begin
      send_bit(1'b1, div);
    end else begin
      send_bit(1'b0, (div * 3) / 4);
      send_bit(1'b1, div);
    end
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_q.push_back(d);
    send_frame(d, 1'b1);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rx_re = 1'b1;
      tick(1);
      rx_re = 1'b0;
    end
  endtask

  initial begin
    rst      = 1'b1;
    baud_div = 16'd104;
    rx_en    = 1'b1;
    rx_bit   = 1'b1;
    rx_re    = 1'b0;
    tick(3);
    check("reset_empty", int'(empty), 1);
    check("reset_full", int'(full), 0);
    check("reset_dout", int'(dout), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick(5);

    // 1: four back-to-back frames
    send_good(8'h41);
    send_good(8'h42);
    send_good(8'h43);
    send_good(8'h0A);
    tick(4);
    check("t1_not_empty", int'(empty), 0);
    check("t1_not_full", int'(full), 0);
    check("t1_no_ferr", ferr_cnt, 0);
    check("t1_no_ovr", ovr_cnt, 0);
    pop_n(4);
    tick(1);
    check("t1_empty_after", int'(empty), 1);

    // 2: 300 ns glitch rejected, then a valid frame
    send_bit(1'b0, 30);
    send_bit(1'b1, 3 * div);
    check("t2_glitch_no_push", int'(empty), 1);
    check("t2_glitch_no_ferr", ferr_cnt, 0);
    send_good(8'h55);
    tick(4);
    check("t2_push", int'(empty), 0);
    pop_n(1);
    tick(1);
    check("t2_empty_after", int'(empty), 1);

    // 3: framing error then recovery
    send_frame(8'hA5, 1'b0);
    tick(4);
    check("t3_ferr_pulse", ferr_cnt, 1);
    check("t3_fifo_unchanged", int'(empty), 1);
    send_good(8'h5A);
    tick(4);
    pop_n(1);
    tick(1);
    check("t3_empty_after", int'(empty), 1);

    // 4: fill to full, then overrun
    for (int i = 0; i < 16; i++) send_good(8'(i));
    tick(4);
    check("t4_full", int'(full), 1);
    check("t4_no_ovr_yet", ovr_cnt, 0);
    send_frame(8'h10, 1'b1);
    tick(4);
    check("t4_overrun", ovr_cnt, 1);
    check("t4_still_full", int'(full), 1);
    pop_n(16);
    tick(1);
    check("t4_empty_after", int'(empty), 1);
    check("t4_full_clear", int'(full), 0);

    // 5: disable mid-frame, then a clean frame
    send_bit(1'b0, div);
    for (int i = 0; i < 3; i++) send_bit(1'b1, div);
    rx_en = 1'b0;
    tick(2);
    send_bit(1'b1, 12 * div);
    rx_en = 1'b1;
    tick(2);
    send_good(8'h3C);
    tick(4);
    check("t5_no_ferr", ferr_cnt, 1);
    check("t5_no_ovr", ovr_cnt, 1);
    pop_n(1);
    tick(1);
    check("t5_only_one", int'(empty), 1);

    // 6: reset mid-frame with bytes queued
    send_good(8'h11);
    send_good(8'h22);
    send_good(8'h33);
    send_bit(1'b0, div);
    send_bit(1'b1, div);
    send_bit(1'b0, div / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_empty", int'(empty), 1);
    check("t6_rst_full", int'(full), 0);
    check("t6_rst_dout", int'(dout), 0);
    exp_q.delete();
    send_bit(1'b1, 10 * div);
    send_good(8'h81);
    tick(4);
    check("t6_push_81", int'(empty), 0);
    pop_n(1);
    tick(1);
    check("t6_empty_after", int'(empty), 1);

    // minimum divisor
    div      = 4;
    baud_div = 16'd4;
    tick(10);
    send_good(8'hC3);
    tick(4);
    check("t6_div4_push", int'(empty), 0);
    pop_n(1);
    tick(1);
    check("t6_div4_empty", int'(empty), 1);

    check("final_ferr", ferr_cnt, 1);
    check("final_ovr", ovr_cnt, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
